// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port general-purpose register file.
//
// Sits between decode (read ports) and writeback (write ports). Reads are
// combinational, and an optional bypass forwards same-cycle writes. Writes are
// registered. When several write ports target the same address, the
// highest-index port wins, because it carries the later instruction in issue
// order. A two-state machine (IDLE/CLEAR) zeroes the array one register per
// cycle to flush the context.
//
// Ports:
//   clk         clock, all state updates on the rising edge
//   rst         synchronous active-high reset (clears array, FSM, outputs)
//   read_ena    [NREAD-1:0]             per-port read enable
//   read_addr   [NREAD-1:0][AW-1:0]     read addresses
//   read_data   [NREAD-1:0][WIDTH-1:0]  combinational read data
//   write_ena   [NWRITE-1:0]            per-port write enable
//   write_addr  [NWRITE-1:0][AW-1:0]    write addresses
//   write_data  [NWRITE-1:0][WIDTH-1:0] write data
//   clear_req   single-cycle request to zero every register
//   busy        registered, high while the clear sequence runs
//   clear_done  registered, one-cycle pulse when the clear sequence finishes
module regfile_mp #(
    parameter int WIDTH    = 32,
    parameter int DEPTH    = 32,
    parameter int NREAD    = 2,
    parameter int NWRITE   = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [NREAD-1:0]               read_ena,
    input  logic [NREAD-1:0][AW-1:0]       read_addr,
    output logic [NREAD-1:0][WIDTH-1:0]    read_data,
    input  logic [NWRITE-1:0]              write_ena,
    input  logic [NWRITE-1:0][AW-1:0]      write_addr,
    input  logic [NWRITE-1:0][WIDTH-1:0]   write_data,
    input  logic                           clear_req,
    output logic                           busy,
    output logic                           clear_done
);

    typedef enum logic {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    state_t           state_q;
    logic [AW-1:0]    ptr_q;
    logic             busy_q;
    logic             done_q;

    // Address 0 is hard-wired to zero when ZERO_REG is set.
    function automatic logic is_zero_reg(input logic [AW-1:0] addr);
        return (ZERO_REG != 0) && (addr == '0);
    endfunction

    // A write port takes effect only if enabled and not aimed at the zero register.
    function automatic logic write_live(input logic en, input logic [AW-1:0] addr);
        return en && !is_zero_reg(addr);
    endfunction

    // Clear FSM. busy/clear_done are registered alongside the state so that
    // busy is high exactly while the FSM sits in CLEAR.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (clear_req) begin
                        state_q <= CLEAR;
                        ptr_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                CLEAR: begin
                    // clear_req is deliberately ignored here.
                    ptr_q <= ptr_q + 1'b1;
                    if (ptr_q == LAST_ADDR) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    // Storage array. Ports are walked in ascending order, so the last
    // assignment (the highest-index port) wins on an address collision.
    // While clearing, the write ports are dropped, and upstream stalls on busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < DEPTH; k++) begin
                mem_q[k] <= '0;
            end
        end else if (state_q == CLEAR) begin
            mem_q[ptr_q] <= '0;
        end else begin
            for (int j = 0; j < NWRITE; j++) begin
                if (write_live(write_ena[j], write_addr[j])) begin
                    mem_q[write_addr[j]] <= write_data[j];
                end
            end
        end
    end

    // Read path: busy and a disabled port force zero, and so does the zero
    // register. A bypass hit overrides the stored value, and the
    // highest-index matching write port has the last word. busy low implies
    // IDLE, so any live write seen here is really performed.
    always_comb begin
        for (int i = 0; i < NREAD; i++) begin
            read_data[i] = '0;
            if (!busy_q && read_ena[i] && !is_zero_reg(read_addr[i])) begin
                read_data[i] = mem_q[read_addr[i]];
                if (BYPASS != 0) begin
                    for (int j = 0; j < NWRITE; j++) begin
                        if (write_live(write_ena[j], write_addr[j]) &&
                            (write_addr[j] == read_addr[i])) begin
                            read_data[i] = write_data[j];
                        end
                    end
                end
            end
        end
    end

    assign busy       = busy_q;
    assign clear_done = done_q;

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp. Two instances share every input: dut_a uses the
// defaults (bypass on, zero register on), dut_b has bypass and zero register
// off. A behavioural model tracks the contents of each instance and the clear
// progress. Directed vectors, hand-written clear/reset sequences and random
// traffic are all checked against that model. The directed vectors also carry
// literal expected values.
module tb_regfile_mp;

    logic               clk = 1'b0;
    logic               rst;
    logic [1:0]         read_ena;
    logic [1:0][4:0]    read_addr;
    logic [1:0][31:0]   rd_a, rd_b;
    logic [1:0]         write_ena;
    logic [1:0][4:0]    write_addr;
    logic [1:0][31:0]   write_data;
    logic               clear_req;
    logic               busy_a, busy_b, done_a, done_b;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    regfile_mp dut_a (
        .clk(clk), .rst(rst),
        .read_ena(read_ena), .read_addr(read_addr), .read_data(rd_a),
        .write_ena(write_ena), .write_addr(write_addr), .write_data(write_data),
        .clear_req(clear_req), .busy(busy_a), .clear_done(done_a)
    );

    regfile_mp #(.BYPASS(0), .ZERO_REG(0)) dut_b (
        .clk(clk), .rst(rst),
        .read_ena(read_ena), .read_addr(read_addr), .read_data(rd_b),
        .write_ena(write_ena), .write_addr(write_addr), .write_data(write_data),
        .clear_req(clear_req), .busy(busy_b), .clear_done(done_b)
    );

    // ---------------- reference model ----------------
    logic [31:0] m_a [32];
    logic [31:0] m_b [32];
    bit          m_busy = 1'b0;
    bit          m_done = 1'b0;
    int          m_cnt  = 0;

    function automatic logic [31:0] model_read(bit is_b, int i);
        bit byp  = !is_b;
        bit zero = !is_b;
        logic [31:0] v;
        if (m_busy || !read_ena[i]) return 32'h0;
        if (zero && read_addr[i] == 5'd0) return 32'h0;
        v = is_b ? m_b[read_addr[i]] : m_a[read_addr[i]];
        if (byp) begin
            for (int j = 0; j < 2; j++) begin
                if (write_ena[j] && write_addr[j] == read_addr[i] &&
                    !(zero && write_addr[j] == 5'd0)) v = write_data[j];
            end
        end
        return v;
    endfunction

    task automatic model_clock();
        if (rst) begin
            for (int k = 0; k < 32; k++) begin m_a[k] = 0; m_b[k] = 0; end
            m_busy = 0; m_done = 0; m_cnt = 0;
        end else if (m_busy) begin
            // Registers are unobservable while clearing (reads return 0 and
            // writes are dropped), so the whole array is zeroed when the
            // DEPTH-cycle sequence completes.
            m_cnt++;
            m_done = 0;
            if (m_cnt == 32) begin
                for (int k = 0; k < 32; k++) begin m_a[k] = 0; m_b[k] = 0; end
                m_busy = 0; m_done = 1;
            end
        end else begin
            m_done = 0;
            for (int j = 0; j < 2; j++) begin
                if (write_ena[j]) begin
                    if (write_addr[j] != 5'd0) m_a[write_addr[j]] = write_data[j];
                    m_b[write_addr[j]] = write_data[j];
                end
            end
            if (clear_req) begin m_busy = 1; m_cnt = 0; end
        end
    endtask

    // ---------------- checking helpers ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Called just after a negedge with inputs applied: checks combinational
    // reads, clocks, then checks the registered outputs on the next negedge.
    task automatic tick();
        #1;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("rdA[%0d]", i), rd_a[i], model_read(1'b0, i));
            chk($sformatf("rdB[%0d]", i), rd_b[i], model_read(1'b1, i));
        end
        @(posedge clk);
        model_clock();
        @(negedge clk);
        chk("busyA", {31'b0, busy_a}, {31'b0, m_busy});
        chk("doneA", {31'b0, done_a}, {31'b0, m_done});
        chk("busyB", {31'b0, busy_b}, {31'b0, m_busy});
        chk("doneB", {31'b0, done_b}, {31'b0, m_done});
    endtask

    task automatic quiet();
        rst = 0; clear_req = 0; write_ena = '0; write_addr = '0;
        write_data = '0; read_ena = '0; read_addr = '0;
    endtask

    // ---------------- directed vector table ----------------
    typedef struct packed {
        logic [1:0]  we;
        logic [4:0]  wa0;
        logic [31:0] wd0;
        logic [4:0]  wa1;
        logic [31:0] wd1;
        logic [1:0]  re;
        logic [4:0]  ra0;
        logic [4:0]  ra1;
        logic [31:0] exp_a0;
        logic [31:0] exp_a1;
        logic [31:0] exp_b0;
    } vec_t;

    vec_t tbl [10];

    initial begin
        int busy_cycles;
        int done_seen;

        for (int k = 0; k < 32; k++) begin m_a[k] = 0; m_b[k] = 0; end

        //            we     wa0   wd0            wa1   wd1            re     ra0   ra1   expA0          expA1          expB0
        tbl[0] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b11, 5'd5, 5'd0, 32'h0,         32'h0,         32'h0};
        tbl[1] = '{2'b01, 5'd3, 32'hDEADBEEF,  5'd0, 32'h0,         2'b01, 5'd3, 5'd0, 32'hDEADBEEF,  32'h0,         32'h0};
        tbl[2] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b11, 5'd3, 5'd3, 32'hDEADBEEF,  32'hDEADBEEF,  32'hDEADBEEF};
        tbl[3] = '{2'b11, 5'd7, 32'h1111,      5'd7, 32'h2222,      2'b11, 5'd7, 5'd3, 32'h2222,      32'hDEADBEEF,  32'h0};
        tbl[4] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b11, 5'd7, 5'd7, 32'h2222,      32'h2222,      32'h2222};
        tbl[5] = '{2'b01, 5'd0, 32'hFFFF,      5'd0, 32'h0,         2'b11, 5'd0, 5'd0, 32'h0,         32'h0,         32'h0};
        tbl[6] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b11, 5'd0, 5'd0, 32'h0,         32'h0,         32'hFFFF};
        tbl[7] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b10, 5'd3, 5'd3, 32'h0,         32'hDEADBEEF,  32'h0};
        tbl[8] = '{2'b11, 5'd9, 32'hA5A5A5A5,  5'd10, 32'h5A5A5A5A, 2'b11, 5'd10, 5'd9, 32'h5A5A5A5A, 32'hA5A5A5A5,  32'h0};
        tbl[9] = '{2'b00, 5'd0, 32'h0,         5'd0, 32'h0,         2'b11, 5'd10, 5'd9, 32'h5A5A5A5A, 32'hA5A5A5A5,  32'h5A5A5A5A};

        // Reset
        quiet();
        @(negedge clk);
        rst = 1;
        tick();
        rst = 0;
        chk("reset_busy", {31'b0, busy_a}, 32'h0);
        chk("reset_done", {31'b0, done_a}, 32'h0);

        // Directed table
        for (int v = 0; v < 10; v++) begin
            write_ena  = tbl[v].we;
            write_addr = {tbl[v].wa1, tbl[v].wa0};
            write_data = {tbl[v].wd1, tbl[v].wd0};
            read_ena   = tbl[v].re;
            read_addr  = {tbl[v].ra1, tbl[v].ra0};
            #1;
            chk($sformatf("vec%0d_a0", v), rd_a[0], tbl[v].exp_a0);
            chk($sformatf("vec%0d_a1", v), rd_a[1], tbl[v].exp_a1);
            chk($sformatf("vec%0d_b0", v), rd_b[0], tbl[v].exp_b0);
            tick();
        end

        // Bulk clear: fill every register with its index
        quiet();
        for (int a = 0; a < 32; a += 2) begin
            write_ena  = 2'b11;
            write_addr = {5'(a + 1), 5'(a)};
            write_data = {32'(a + 1), 32'(a)};
            tick();
        end
        quiet();
        for (int a = 0; a < 32; a++) begin
            read_ena  = 2'b11;
            read_addr = {5'(31 - a), 5'(a)};
            tick();
        end
        clear_req = 1;
        read_ena  = 2'b11;
        read_addr = {5'd4, 5'd3};
        tick();
        clear_req   = 0;
        busy_cycles = busy_a ? 1 : 0;
        done_seen   = 0;
        for (int c = 0; c < 40; c++) begin
            write_ena  = busy_a ? 2'b01 : 2'b00;
            write_addr = {5'd0, 5'd5};
            write_data = {32'h0, 32'h0BAD0BAD};
            read_ena   = 2'b11;
            read_addr  = {5'd5, 5'(c)};
            clear_req  = (c == 10);
            tick();
            if (busy_a) busy_cycles++;
            if (done_a) done_seen++;
        end
        chk("clear_busy_len", 32'(busy_cycles), 32'd32);
        chk("clear_done_cnt", 32'(done_seen), 32'd1);
        quiet();
        for (int a = 0; a < 32; a++) begin
            read_ena  = 2'b11;
            read_addr = {5'(a), 5'(a)};
            #1;
            chk($sformatf("cleared_a[%0d]", a), rd_a[0], 32'h0);
            chk($sformatf("cleared_b[%0d]", a), rd_b[1], 32'h0);
            tick();
        end

        // Reset in the middle of a clear
        quiet();
        for (int a = 1; a < 5; a++) begin
            write_ena = 2'b01; write_addr = {5'd0, 5'(a)}; write_data = {32'h0, 32'(a * 3)};
            tick();
        end
        quiet();
        clear_req = 1;
        tick();
        clear_req = 0;
        for (int c = 0; c < 10; c++) tick();
        rst = 1;
        tick();
        rst = 0;
        chk("midclr_busy", {31'b0, busy_a}, 32'h0);
        done_seen = 0;
        for (int c = 0; c < 40; c++) begin
            read_ena  = 2'b11;
            read_addr = {5'(31 - (c % 32)), 5'(c % 32)};
            tick();
            if (done_a || done_b) done_seen++;
        end
        chk("midclr_no_done", 32'(done_seen), 32'd0);

        // Random traffic
        quiet();
        for (int c = 0; c < 600; c++) begin
            rst        = ($urandom_range(0, 149) == 0);
            clear_req  = ($urandom_range(0, 59) == 0);
            write_ena  = 2'($urandom);
            read_ena   = 2'($urandom);
            for (int p = 0; p < 2; p++) begin
                write_addr[p] = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                read_addr[p]  = ($urandom_range(0, 1) == 0) ? 5'($urandom_range(0, 3)) : 5'($urandom);
                write_data[p] = $urandom;
            end
            tick();
        end

        quiet();
        tick();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file. Successor to the fixed 2R/2W dual-issue regfile.
- Adds the following over the fixed block:
  - configurable depth, width and port counts;
  - optional write-to-read bypass;
  - defined priority when two write ports target the same address;
  - a multi-cycle bulk-clear state machine used for context flush.
- Sits between decode (read ports) and writeback (write ports) of the issue pipeline.

Parameters:
- WIDTH, 32, data bits per register.
- DEPTH, 32, number of registers; power of two, ≥ 2. Derived AW = $clog2(DEPTH).
- NREAD, 2, number of read ports (≥ 1).
- NWRITE, 2, number of write ports (≥ 1).
- BYPASS, 1, 1 = a same-cycle write is forwarded to a matching read; 0 = reads see stored contents only.
- ZERO_REG, 1, 1 = address 0 always reads 0 and writes to it are discarded; 0 = register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- read_ena  in  [NREAD-1:0]  per-port read enable.
- read_addr  in  [NREAD-1:0][AW-1:0]  read addresses.
- read_data  out  [NREAD-1:0][WIDTH-1:0]  combinational read data.
- write_ena  in  [NWRITE-1:0]  per-port write enable.
- write_addr  in  [NWRITE-1:0][AW-1:0]  write addresses.
- write_data  in  [NWRITE-1:0][WIDTH-1:0]  write data.
- clear_req  in  1  single-cycle request to zero all registers.
- busy  out  1  high while the clear sequence runs.
- clear_done  out  1  one-cycle pulse when the clear sequence finishes.

Behaviour:
- Reset (rst=1 at a posedge), all in one cycle:
  - every register ← 0;
  - FSM ← IDLE, clear pointer ← 0;
  - busy=0, clear_done=0.
  - rst dominates clear_req and all writes in the same cycle.
  - rst asserted mid-clear aborts the sequence; no clear_done pulse is produced.
- Read path (combinational, zero latency), per port i, in priority order:
  1. busy=1 → 0.
  2. read_ena[i]=0 → 0.
  3. ZERO_REG=1 and read_addr[i]=0 → 0.
  4. BYPASS=1 and some write port j has write_ena[j]=1 and write_addr[j]=read_addr[i] (and that write is not discarded) → write_data of the highest-index such j.
  5. Otherwise → stored register contents.
- Write path (registered, in IDLE only), at posedge:
  - each enabled port writes its data to its address;
  - writes to address 0 are discarded when ZERO_REG=1;
  - if several enabled ports hit the same address, the highest-index port wins (later instruction in issue order);
  - a write is visible to a non-bypassed read on the next cycle.
- Clear FSM, states IDLE and CLEAR:
  - IDLE, clear_req=1 → CLEAR; pointer ← 0.
    - Writes presented in that same cycle are still performed.
  - CLEAR, each cycle:
    - register[pointer] ← 0, pointer ← pointer+1;
    - busy=1;
    - all write ports ignored and dropped; upstream must stall on busy.
  - CLEAR, pointer=DEPTH-1:
    - zero the last register;
    - next state IDLE;
    - clear_done=1 in the following cycle, for exactly one cycle, with busy=0.
  - clear_req during CLEAR is ignored; it neither restarts nor extends the sequence.
  - Total: busy is high for exactly DEPTH cycles after the request cycle.
- busy and clear_done are registered outputs.
- No X propagation: read data for unwritten registers is 0, because reset clears everything.

Test Plan:
- Reset then read: rst 1 cycle, then read_ena=2'b11, read_addr={5,0} → read_data={0,0}; busy=0, clear_done=0.
- Write/readback: port0 writes addr 3 ← 32'hDEADBEEF. With BYPASS=1, port0 reads addr 3 in the same cycle → DEADBEEF; next cycle also → DEADBEEF. With BYPASS=0, same cycle → 0, next cycle → DEADBEEF.
- Write conflict:
  - port0 addr 7 ← 32'h1111 and port1 addr 7 ← 32'h2222 in the same cycle → addr 7 reads 32'h2222 afterwards;
  - a bypassed read in that cycle → 32'h2222.
- Zero register: ZERO_REG=1, write addr 0 ← 32'hFFFF → read addr 0 returns 0, both bypassed and next cycle.
- Bulk clear:
  - fill all 32 registers with their index, then pulse clear_req;
  - busy is high for 32 cycles; a write issued during busy is dropped; reads return 0 while busy;
  - clear_done pulses once; every register then reads 0;
  - a second clear_req asserted mid-sequence does not extend busy.
- Reset mid-clear: assert rst at cycle 10 of CLEAR → next cycle busy=0, no clear_done pulse, all registers read 0.
